// File: rtl/regfile_rename_pkg.sv
// Shared machine-width definitions for the register file, ROB and LSB.
// Register index helper keeps the "x0 is hardwired" rule in one place.
package regfile_rename_pkg;

   localparam int REG_LEN  = 5;
   localparam int ROB_LEN  = 4;
   localparam int DATA_LEN = 32;
   localparam int REG_NUM  = 32;
   localparam int ROB_MAX  = 16;

   function automatic logic rd_writable(input logic [REG_LEN-1:0] rd);
      return rd != '0;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One issue-stage source lookup: selects register state and forwards a
// same-cycle commit whose tag matches the in-flight producer.
module regfile_read_port
   import regfile_rename_pkg::*;
#(
   parameter int REG_NUM = regfile_rename_pkg::REG_NUM,
   parameter int ROB_W   = ROB_LEN,
   parameter int DATA_W  = DATA_LEN
) (
   input  logic [REG_LEN-1:0]              i_idx,
   input  logic [REG_NUM-1:0][DATA_W-1:0]  i_val,
   input  logic [REG_NUM-1:0]              i_busy,
   input  logic [REG_NUM-1:0][ROB_W-1:0]   i_tag,
   input  logic                            i_unlock,
   input  logic [REG_LEN-1:0]              i_unlock_rd,
   input  logic [ROB_W-1:0]                i_unlock_robpos,
   input  logic [DATA_W-1:0]               i_unlock_val,
   output logic                            o_busy,
   output logic [ROB_W-1:0]                o_robpos,
   output logic [DATA_W-1:0]               o_val
);

   logic w_hit;

   always_comb begin
      w_hit    = 1'b0;
      o_busy   = 1'b0;
      o_robpos = '0;
      o_val    = '0;
      if (rd_writable(i_idx)) begin
         // A pending rename is deliberately invisible here: issue sees the old producer.
         w_hit    = i_unlock && (i_unlock_rd == i_idx) && i_busy[i_idx]
                    && (i_tag[i_idx] == i_unlock_robpos);
         o_busy   = i_busy[i_idx] & ~w_hit;
         o_robpos = i_tag[i_idx];
         o_val    = w_hit ? i_unlock_val : i_val[i_idx];
      end
   end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags; commits free a
// register only when they come from its most recent producer.
module regfile_rename
   import regfile_rename_pkg::*;
#(
   parameter int REG_NUM = regfile_rename_pkg::REG_NUM,
   parameter int ROB_W   = ROB_LEN,
   parameter int DATA_W  = DATA_LEN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ready,
   input  logic               clear,
   input  logic [4:0]         rs1_idx,
   input  logic [4:0]         rs2_idx,
   output logic               rs1_busy,
   output logic               rs2_busy,
   output logic [ROB_W-1:0]   rs1_robpos,
   output logic [ROB_W-1:0]   rs2_robpos,
   output logic [DATA_W-1:0]  rs1_val,
   output logic [DATA_W-1:0]  rs2_val,
   input  logic               rename,
   input  logic [4:0]         rename_rd,
   input  logic [ROB_W-1:0]   rename_robpos,
   input  logic               unlock,
   input  logic [4:0]         unlock_rd,
   input  logic [ROB_W-1:0]   unlock_robpos,
   input  logic [DATA_W-1:0]  unlock_val
);

   logic [REG_NUM-1:0][DATA_W-1:0] r_val;
   logic [REG_NUM-1:0]             r_busy;
   logic [REG_NUM-1:0][ROB_W-1:0]  r_tag;

   logic w_commit;
   logic w_rename;

   assign w_commit = unlock & rd_writable(unlock_rd);
   assign w_rename = rename & ~clear & rd_writable(rename_rd);

   // Statement order matters: clear overrides commit's busy drop, rename overrides both.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_val  <= '0;
         r_busy <= '0;
         r_tag  <= '0;
      end else if (ready) begin
         if (w_commit) begin
            r_val[unlock_rd] <= unlock_val;
            if (r_tag[unlock_rd] == unlock_robpos) r_busy[unlock_rd] <= 1'b0;
         end
         if (clear) r_busy <= '0;
         if (w_rename) begin
            r_busy[rename_rd] <= 1'b1;
            r_tag[rename_rd]  <= rename_robpos;
         end
      end
   end

   regfile_read_port #(.REG_NUM(REG_NUM), .ROB_W(ROB_W), .DATA_W(DATA_W)) u_rs1 (
      .i_idx           (rs1_idx),
      .i_val           (r_val),
      .i_busy          (r_busy),
      .i_tag           (r_tag),
      .i_unlock        (unlock),
      .i_unlock_rd     (unlock_rd),
      .i_unlock_robpos (unlock_robpos),
      .i_unlock_val    (unlock_val),
      .o_busy          (rs1_busy),
      .o_robpos        (rs1_robpos),
      .o_val           (rs1_val)
   );

   regfile_read_port #(.REG_NUM(REG_NUM), .ROB_W(ROB_W), .DATA_W(DATA_W)) u_rs2 (
      .i_idx           (rs2_idx),
      .i_val           (r_val),
      .i_busy          (r_busy),
      .i_tag           (r_tag),
      .i_unlock        (unlock),
      .i_unlock_rd     (unlock_rd),
      .i_unlock_robpos (unlock_robpos),
      .i_unlock_val    (unlock_val),
      .o_busy          (rs2_busy),
      .o_robpos        (rs2_robpos),
      .o_val           (rs2_val)
   );

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: expected lookups are queued as stimulus
// is applied and compared against both read ports once settled.
module tb_regfile_rename;

   logic        clk = 1'b0;
   logic        reset, ready, clear;
   logic [4:0]  rs1_idx, rs2_idx;
   logic        rs1_busy, rs2_busy;
   logic [3:0]  rs1_robpos, rs2_robpos;
   logic [31:0] rs1_val, rs2_val;
   logic        rename, unlock;
   logic [4:0]  rename_rd, unlock_rd;
   logic [3:0]  rename_robpos, unlock_robpos;
   logic [31:0] unlock_val;

   regfile_rename #(.REG_NUM(32), .ROB_W(4), .DATA_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .ready         (ready),
      .clear         (clear),
      .rs1_idx       (rs1_idx),
      .rs2_idx       (rs2_idx),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .rs1_robpos    (rs1_robpos),
      .rs2_robpos    (rs2_robpos),
      .rs1_val       (rs1_val),
      .rs2_val       (rs2_val),
      .rename        (rename),
      .rename_rd     (rename_rd),
      .rename_robpos (rename_robpos),
      .unlock        (unlock),
      .unlock_rd     (unlock_rd),
      .unlock_robpos (unlock_robpos),
      .unlock_val    (unlock_val)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          port;
      logic        busy;
      logic [3:0]  tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Tag is meaningful only while busy, value only while not busy.
   function automatic logic [36:0] norm(input logic b, input logic [3:0] t, input logic [31:0] v);
      return b ? {1'b1, t, 32'h0} : {1'b0, 4'h0, v};
   endfunction

   task automatic sb_push(input string name, input int port, input logic b,
                          input logic [3:0] t, input logic [31:0] v);
      exp_t e;
      e.name = name; e.port = port; e.busy = b; e.tag = t; e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [36:0] obs, expv;
      #1;
      while (sb.size() > 0) begin
         e    = sb.pop_front();
         obs  = (e.port == 1) ? norm(rs1_busy, rs1_robpos, rs1_val)
                              : norm(rs2_busy, rs2_robpos, rs2_val);
         expv = norm(e.busy, e.tag, e.val);
         n_tests++;
         assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed busy/tag/val=%h expected %h", e.name, obs, expv);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ready = 1'b1; clear = 1'b0; rename = 1'b0; unlock = 1'b0;
      rename_rd = '0; rename_robpos = '0;
      unlock_rd = '0; unlock_robpos = '0; unlock_val = '0;
   endtask

   task automatic do_rename(input logic [4:0] rd, input logic [3:0] tag);
      rename = 1'b1; rename_rd = rd; rename_robpos = tag;
   endtask

   task automatic do_unlock(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
      unlock = 1'b1; unlock_rd = rd; unlock_robpos = tag; unlock_val = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b0; rs1_idx = 5'd5; rs2_idx = 5'd0;
      #3;
      sb_push("reset_rs1", 1, 0, 0, 0);
      sb_push("reset_rs2", 2, 0, 0, 0);
      drain();
      tick();
      reset = 1'b1;
      tick();

      // rename x3 tag 7, producer visible next cycle, then bypassed commit
      do_rename(5'd3, 4'd7); rs2_idx = 5'd3;
      sb_push("no_same_cycle_rename_bypass", 2, 0, 0, 0);
      drain(); tick(); idle();
      rs1_idx = 5'd3;
      sb_push("x3_busy", 1, 1, 7, 0);
      drain();
      do_unlock(5'd3, 4'd7, 32'hDEADBEEF);
      sb_push("x3_bypass", 1, 0, 0, 32'hDEADBEEF);
      drain(); tick(); idle();
      sb_push("x3_committed", 1, 0, 0, 32'hDEADBEEF);
      drain();

      // stale commit on x4: value stored, younger producer kept
      do_rename(5'd4, 4'd2); tick();
      do_rename(5'd4, 4'd9); tick(); idle();
      do_unlock(5'd4, 4'd2, 32'h11); rs1_idx = 5'd4;
      sb_push("x4_stale_no_bypass", 1, 1, 9, 0);
      drain(); tick(); idle();
      sb_push("x4_still_busy", 1, 1, 9, 0);
      drain();

      // same-cycle rename and matching commit on x6
      do_rename(5'd6, 4'd3); tick(); idle();
      do_rename(5'd6, 4'd5); do_unlock(5'd6, 4'd3, 32'h22); rs1_idx = 5'd6;
      sb_push("x6_bypass_prerename", 1, 0, 0, 32'h22);
      drain(); tick(); idle();
      sb_push("x6_rename_wins", 1, 1, 5, 0);
      drain();

      // flush with commit to x8 and rename to x9
      do_rename(5'd8, 4'd1); tick(); idle();
      clear = 1'b1; do_unlock(5'd8, 4'd1, 32'h33); do_rename(5'd9, 4'd12);
      tick(); idle();
      rs1_idx = 5'd8; rs2_idx = 5'd9;
      sb_push("clear_x8_val", 1, 0, 0, 32'h33);
      sb_push("clear_x9_ignored", 2, 0, 0, 0);
      drain();
      rs1_idx = 5'd4; rs2_idx = 5'd6;
      sb_push("clear_x4_stale_val", 1, 0, 0, 32'h11);
      sb_push("clear_x6_val", 2, 0, 0, 32'h22);
      drain();

      // tags compare exactly: slot 0 does not retire slot 15
      do_rename(5'd12, 4'd15); tick(); idle();
      do_unlock(5'd12, 4'd0, 32'h66); rs1_idx = 5'd12;
      sb_push("x12_tag0_no_bypass", 1, 1, 15, 0);
      drain(); tick(); idle();
      sb_push("x12_tag0_still_busy", 1, 1, 15, 0);
      drain();
      do_unlock(5'd12, 4'd15, 32'h77);
      sb_push("x12_tag15_bypass", 1, 0, 0, 32'h77);
      drain(); tick(); idle();
      sb_push("x12_tag15_committed", 1, 0, 0, 32'h77);
      drain();

      // x0 is never renamed or written
      do_rename(5'd0, 4'd3); do_unlock(5'd0, 4'd0, 32'h44); rs1_idx = 5'd0;
      sb_push("x0_during_write", 1, 0, 0, 0);
      drain(); tick(); idle();
      sb_push("x0_after_write", 1, 0, 0, 0);
      drain();

      // stall holds state
      ready = 1'b0; do_rename(5'd10, 4'd4); tick(); idle();
      rs1_idx = 5'd10;
      sb_push("x10_stalled_rename", 1, 0, 0, 0);
      drain();
      do_rename(5'd11, 4'd6); tick(); idle();
      ready = 1'b0; clear = 1'b1; rs1_idx = 5'd11;
      sb_push("x11_busy_before_stalled_clear", 1, 1, 6, 0);
      drain(); tick(); idle();
      sb_push("x11_busy_after_stalled_clear", 1, 1, 6, 0);
      drain();

      // asynchronous reset mid-cycle with x5 in flight
      do_rename(5'd5, 4'd11); tick(); idle();
      rs1_idx = 5'd5; rs2_idx = 5'd3;
      sb_push("x5_busy_before_reset", 1, 1, 11, 0);
      drain();
      #2 reset = 1'b0;
      sb_push("x5_async_reset", 1, 0, 0, 0);
      sb_push("x3_async_reset", 2, 0, 0, 0);
      drain();
      tick();
      reset = 1'b1;
      do_rename(5'd5, 4'd1); tick(); idle();
      sb_push("x5_rename_after_reset", 1, 1, 1, 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_rename.md
REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 SHALL have parameters: REG_NUM, 32, number of architectural registers; ROB_W, 4, ROB tag width (16 entries); DATA_W, 32, data width.
REQ-002 SHALL have ports: clk  in  1  system clock.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ready  in  1  global stall; state updates only when 1.
REQ-005 SHALL have ports: clear  in  1  misprediction flush from the ROB.
REQ-006 SHALL have ports: rs1_idx, rs2_idx  in  5  issue-stage source register indices.
REQ-007 SHALL have ports: rs1_busy, rs2_busy  out  1  source awaits an in-flight producer.
REQ-008 SHALL have ports: rs1_robpos, rs2_robpos  out  ROB_W  producer tag, valid when busy.
REQ-009 SHALL have ports: rs1_val, rs2_val  out  DATA_W  architectural value, valid when not busy.
REQ-010 SHALL have ports: rename  in  1  an issued instruction claims rd.
REQ-011 SHALL have ports: rename_rd  in  5  destination register.
REQ-012 SHALL have ports: rename_robpos  in  ROB_W  ROB slot of the claiming instruction.
REQ-013 SHALL have ports: unlock  in  1  ROB commit of a register-writing instruction.
REQ-014 SHALL have ports: unlock_rd  in  5  committed destination register.
REQ-015 SHALL have ports: unlock_robpos  in  ROB_W  committed ROB slot.
REQ-016 SHALL have ports: unlock_val  in  DATA_W  committed value.

Function
REQ-017 SHALL hold per register: val[DATA_W], busy[1], tag[ROB_W].
REQ-018 SHALL produce lookup outputs combinationally from current state plus same-cycle commit bypass.
REQ-019 SHALL report busy=0, val=0, tag=0 for index 0 at all times; x0 never written, renamed, or busy.
REQ-020 SHALL perform commit on an edge when ready&unlock&(unlock_rd!=0): val<=unlock_val; busy<=0 only if tag==unlock_robpos, else busy/tag unchanged.
REQ-021 SHALL perform rename on an edge when ready&rename&!clear&(rename_rd!=0): busy<=1, tag<=rename_robpos.
REQ-022 SHALL apply both when rename and commit hit the same register in one cycle: val written, busy=1, tag=rename_robpos (rename wins).
REQ-023 SHALL bypass: if unlock&(rsX_idx==unlock_rd!=0)&busy&(tag==unlock_robpos), output busy=0, val=unlock_val that cycle.
REQ-024 SHALL NOT bypass a same-cycle rename; the issuing instruction sees pre-rename state (rd==rs reads the old producer).
REQ-025 SHALL, on an edge when ready&clear: apply any commit value write, clear every busy bit, ignore rename.
REQ-026 SHALL, on an edge when ready=0: hold all state regardless of rename/unlock/clear; lookups remain live.
REQ-027 SHALL ignore a tag mismatch on commit silently (stale producer superseded by a younger rename).
REQ-028 SHALL compare tags at full ROB_W; slot wrap-around needs no special handling since tags are exact slot ids.

Reset
REQ-029 SHALL, on reset low, immediately set all val=0, busy=0, tag=0 independent of clk, dominating ready/clear/rename/unlock.
REQ-030 SHALL have outputs that follow the reset state combinationally (busy=0, val=0, robpos=0) while reset is low.
REQ-031 SHALL resume normal updates on the first clk edge after reset deasserts.

Structure
REQ-032 SHALL take REG_LEN, ROB_LEN, DATA_LEN, REG_NUM and ROB_MAX from the shared definitions header used by the ROB and LSB.
REQ-033 SHALL implement the lookup/bypass as sub-module regfile_read_port, instantiated twice (rs1, rs2).
REQ-034 SHALL keep state arrays and update logic in regfile_rename only.

Verification
REQ-035 SHALL cover: reset low mid-run with x5 busy -> immediate rs1_busy=0, rs1_val=0 for idx 5.
REQ-036 SHALL cover: rename x3 tag 7; next cycle lookup x3 -> busy=1, robpos=7; unlock x3 tag 7 val 0xDEADBEEF -> bypass val 0xDEADBEEF, busy=0 that cycle and thereafter.
REQ-037 SHALL cover: rename x4 tag 2, then x4 tag 9; commit x4 tag 2 val 0x11 -> val=0x11 stored, busy=1, robpos=9.
REQ-038 SHALL cover: same cycle rename x6 tag 5 and commit x6 tag 3 (matching) val 0x22 -> next cycle busy=1, robpos=5, val=0x22.
REQ-039 SHALL cover: clear with unlock x8 val 0x33 and rename x9 -> all busy=0, x8=0x33, x9 unchanged.
REQ-040 SHALL cover: rename/unlock to x0 val 0x44, and ready=0 with rename x10 -> x0 reads 0 not busy; x10 unchanged.
